// File: rtl/comp_seq_16.sv
// comp_seq_16: multi-cycle unsigned magnitude comparator.
// A single SLICE-bit compare stage walks the latched operands from the most
// significant slice down. It stops at the first unequal slice, or after the
// last slice when all slices are equal.
module comp_seq_16 #(
    parameter  int WIDTH  = 16,
    parameter  int SLICE  = 4,
    localparam int NSLICE = WIDTH / SLICE,
    localparam int CW     = $clog2(NSLICE) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic [CW-1:0]    slices_used
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] NSLICE_C = CW'(NSLICE);
    localparam logic [CW-1:0] TOP_IDX  = CW'(NSLICE - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic             slice_gt;
    logic             slice_lt;
    logic             last_slice;

    // Select the slice under examination and compare it.
    always_comb begin
        a_sh       = a_q >> (idx * SLICE);
        b_sh       = b_q >> (idx * SLICE);
        slice_a    = a_sh[SLICE-1:0];
        slice_b    = b_sh[SLICE-1:0];
        slice_gt   = slice_a > slice_b;
        slice_lt   = slice_a < slice_b;
        last_slice = (idx == '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its inputs from before the edge, independent of block order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; abort wins over the slice compare in CMP.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = CMP;
            CMP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (slice_gt || slice_lt || last_slice) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on accept; held constant for the whole compare.
    always_ff @(posedge clk) begin
        // NOTE: operand registers are deliberately not reset; they are always
        // loaded on accept before anything reads them.
        if (state_q == IDLE && start && !rst) begin
            a_q <= A;
            b_q <= B;
        end
    end

    // Slice index and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            a_gt_b      <= 1'b0;
            a_eq_b      <= 1'b0;
            a_lt_b      <= 1'b0;
            slices_used <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        idx         <= TOP_IDX;
                        a_gt_b      <= 1'b0;
                        a_eq_b      <= 1'b0;
                        a_lt_b      <= 1'b0;
                        slices_used <= '0;
                    end
                end
                CMP: begin
                    if (!abort) begin
                        if (slice_gt) begin
                            a_gt_b      <= 1'b1;
                            slices_used <= NSLICE_C - idx;
                        end else if (slice_lt) begin
                            a_lt_b      <= 1'b1;
                            slices_used <= NSLICE_C - idx;
                        end else if (last_slice) begin
                            a_eq_b      <= 1'b1;
                            slices_used <= NSLICE_C;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == CMP);
    assign done  = (state_q == DONE);

endmodule
